// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer for the word-wide data memory macro.
// Handles lane extract/extend, sub-word RMW stores and access checks.
module lsu_mem_ctrl #(
  parameter int ADDRESS_SIZE = 12,
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [2:0]              req_funct3,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [N-1:0]            req_wdata,
  output logic                    resp_valid,
  output logic [N-1:0]            resp_rdata,
  output logic                    resp_error,
  output logic [ADDRESS_SIZE-1:0] mem_a,
  output logic [N-1:0]            mem_d,
  output logic                    mem_we,
  input  logic [N-1:0]            mem_spo
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_RD,
    STORE_WR,
    RESP
  } state_t;

  state_t                  state;
  logic                    wr_q;
  logic [2:0]              f3_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [N-1:0]            wdata_q;
  logic [N-1:0]            merge_q;

  logic                    illegal;
  logic                    misaligned;
  logic [4:0]              sh;
  logic [15:0]             lane;
  logic [N-1:0]            ld_data;
  logic [N-1:0]            mask;
  logic [N-1:0]            merged;

  always_comb begin
    illegal = (req_funct3 == 3'b011)
            || (req_funct3[2:1] == 2'b11)
            || (req_write && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
               || ((req_funct3[1:0] == 2'b10)
                   && (req_addr[1:0] != 2'b00));
  end

  // An aligned half has addr[0]=0, so one byte shift serves both sizes.
  assign sh   = {addr_q[1:0], 3'b000};
  assign lane = 16'(mem_spo >> sh);

  always_comb begin
    ld_data = mem_spo;
    unique case (1'b1)
      f3_q == 3'b000: ld_data = {{(N-8){lane[7]}}, lane[7:0]};
      f3_q == 3'b001: ld_data = {{(N-16){lane[15]}}, lane};
      f3_q == 3'b100: ld_data = {{(N-8){1'b0}}, lane[7:0]};
      f3_q == 3'b101: ld_data = {{(N-16){1'b0}}, lane};
      default:        ld_data = mem_spo;
    endcase
  end

  always_comb begin
    mask = {{(N-16){1'b0}}, 16'hffff} << sh;
    if (f3_q[1:0] == 2'b00)
      mask = {{(N-8){1'b0}}, 8'hff} << sh;
    merged = (mem_spo & ~mask) | ((wdata_q << sh) & mask);
  end

  assign mem_a  = (state == IDLE) ? '0
                : {2'b00, addr_q[ADDRESS_SIZE-1:2]};
  assign mem_we = (state == STORE_WR) & wr_q & ~rst;
  assign mem_d  = (state != STORE_WR) ? '0
                : (f3_q[1:0] == 2'b10) ? wdata_q : merge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      wr_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wr_q      <= req_write;
            f3_q      <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (illegal || misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_write) begin
              state <= LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              state <= STORE_WR;
            end else begin
              state <= STORE_RD;
            end
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= ld_data;
        end
        STORE_RD: begin
          state   <= STORE_WR;
          merge_q <= merged;
        end
        STORE_WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed requests, queued expectations,
// negedge monitor for responses and macro writes.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [11:0] mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_spo;

  logic [31:0] mem [0:4095];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          at;
    logic [31:0] rd;
    logic        err;
  } resp_t;

  typedef struct {
    int          at;
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];

  lsu_mem_ctrl #(.ADDRESS_SIZE(12), .N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .mem_spo    (mem_spo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_spo = mem[mem_a];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (rq.size() == 0) begin
        chk("unexpected resp_valid", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = rq.pop_front();
        chk("resp cycle", cyc, e.at);
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected mem_we", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("write cycle", cyc, w.at);
        chk("mem_a", {20'd0, mem_a}, {20'd0, w.a});
        chk("mem_d", mem_d, w.d);
      end
    end
  end

  task automatic wait_accept(output int t);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pending resp", rq.size(), 32'd0);
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input logic exp_we,
                       input logic [31:0] exp_md);
    int    t;
    resp_t r;
    wr_t   w;
    @(posedge clk) #1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    wait_accept(t);
    r.at = t + lat;
    r.rd = exp_rd;
    r.err = exp_err;
    rq.push_back(r);
    if (exp_we) begin
      w.at = t + lat - 1;
      w.a  = {2'b00, a[11:2]};
      w.d  = exp_md;
      wq.push_back(w);
    end
    @(posedge clk) #1;
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_funct3 = 3'b011;
    req_addr   = ~a;
    req_wdata  = ~wd;
  endtask

  initial begin
    int    t;
    int    t2;
    resp_t r;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h040] = 32'h8899aabb;
    mem[12'h041] = 32'h11223344;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_a", {20'd0, mem_a}, 32'd0);
    chk("rst mem_d", mem_d, 32'd0);
    @(posedge clk) #1 rst = 1'b0;

    // loads from 0x8899aabb
    issue(0, 3'b000, 12'h101, 0, 32'hffffffaa, 0, 2, 0, 0);
    issue(0, 3'b100, 12'h103, 0, 32'h00000088, 0, 2, 0, 0);
    issue(0, 3'b001, 12'h102, 0, 32'hffff8899, 0, 2, 0, 0);
    issue(0, 3'b101, 12'h100, 0, 32'h0000aabb, 0, 2, 0, 0);
    // half store RMW then readback
    issue(1, 3'b001, 12'h102, 32'hcafe1234, 0, 0, 3, 1,
          32'h1234aabb);
    issue(0, 3'b010, 12'h100, 0, 32'h1234aabb, 0, 2, 0, 0);
    // byte stores across all lanes of 0x11223344
    issue(1, 3'b000, 12'h104, 32'hffffff5a, 0, 0, 3, 1,
          32'h1122335a);
    issue(1, 3'b000, 12'h105, 32'hffffff5a, 0, 0, 3, 1,
          32'h11225a5a);
    issue(1, 3'b000, 12'h106, 32'hffffff5a, 0, 0, 3, 1,
          32'h115a5a5a);
    issue(1, 3'b000, 12'h107, 32'hffffff5a, 0, 0, 3, 1,
          32'h5a5a5a5a);
    issue(0, 3'b010, 12'h104, 0, 32'h5a5a5a5a, 0, 2, 0, 0);
    // errors
    issue(0, 3'b010, 12'h102, 0, 32'h0, 1, 1, 0, 0);
    issue(1, 3'b100, 12'h100, 32'h000000ff, 32'h0, 1, 1, 0, 0);
    issue(1, 3'b101, 12'h100, 32'h0000ffff, 32'h0, 1, 1, 0, 0);
    issue(0, 3'b001, 12'h101, 0, 32'h0, 1, 1, 0, 0);
    issue(0, 3'b011, 12'h100, 0, 32'h0, 1, 1, 0, 0);
    issue(0, 3'b110, 12'h100, 0, 32'h0, 1, 1, 0, 0);
    issue(1, 3'b001, 12'h103, 32'h00001111, 32'h0, 1, 1, 0, 0);
    // word store then sub-word loads
    issue(1, 3'b010, 12'h108, 32'hdeadbeef, 0, 0, 2, 1,
          32'hdeadbeef);
    issue(0, 3'b000, 12'h10b, 0, 32'hffffffde, 0, 2, 0, 0);
    issue(0, 3'b101, 12'h10a, 0, 32'h0000dead, 0, 2, 0, 0);
    issue(0, 3'b100, 12'h108, 0, 32'h000000ef, 0, 2, 0, 0);
    drain();
    chk("mem word 0x40", mem[12'h040], 32'h1234aabb);
    chk("mem word 0x41", mem[12'h041], 32'h5a5a5a5a);

    // reset during STORE_WR of a byte store
    @(posedge clk) #1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 12'h100;
    req_wdata  = 32'h00000077;
    req_valid  = 1'b1;
    wait_accept(t);
    @(posedge clk) #1 req_valid = 1'b0;
    @(posedge clk) #1 rst = 1'b1;
    @(negedge clk);
    chk("abort mem_a", {20'd0, mem_a}, 32'h040);
    chk("abort mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    chk("abort req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort mem unchanged", mem[12'h040], 32'h1234aabb);
    repeat (3) @(negedge clk);

    // request held while busy; address changes must be ignored
    @(posedge clk) #1;
    req_write  = 1'b0;
    req_funct3 = 3'b101;
    req_addr   = 12'h108;
    req_valid  = 1'b1;
    wait_accept(t);
    r.at = t + 2;
    r.rd = 32'h0000beef;
    r.err = 1'b0;
    rq.push_back(r);
    @(posedge clk) #1 req_addr = 12'h10a;
    @(negedge clk);
    chk("busy ready T+1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("busy ready T+2", {31'd0, req_ready}, 32'd0);
    wait_accept(t2);
    chk("second accept cycle", t2, t + 3);
    r.at = t2 + 2;
    r.rd = 32'h0000dead;
    rq.push_back(r);
    @(posedge clk) #1 req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("pending writes", wq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
